// File: rtl/mem_unit_sequencer.sv
// ----------------------------------------------------------------------------
// mem_unit_sequencer
//
// Memory execution unit behind the memory reservation station. It accepts one
// LD or STR at a time and runs it through a fixed MEM_LAT-cycle access to a
// small internal data memory (2**ADDR_W words of DATA_W bits).
//   - A LD result is offered on the CDB (cdb_req/cdb_gnt handshake). The
//     result is held stable until the arbiter grants it.
//   - A STR is written on the last access cycle. Its completion is then
//     reported to the ROB as a one-cycle st_done pulse.
// The unit keeps only one op in flight, so ordering is trivially in-order and
// a LD that follows a STR to the same address sees the stored value.
//
// Optional feature (compile-time macro MEM_STALL_CNT_EN):
//   Adds the stall_cnt output. It is an 8-bit saturating count of the cycles
//   in which a CDB request was pending and not granted.
//
// Ports
//   clk          clock; all state changes on its rising edge
//   rst          synchronous, active-high reset
//   req_valid    RS offers a ready LD/STR
//   req_ready    unit can take an op (IDLE only)
//   req_opcode   3'b101 = LD, 3'b110 = STR; anything else is flagged illegal
//   req_val      STR data (ignored for LD)
//   req_addr     memory address
//   req_rob_idx  ROB tag of the op
//   cdb_req      LD result pending broadcast
//   cdb_gnt      arbiter grant, only meaningful while cdb_req=1
//   cdb_rob_idx  tag of the LD result
//   cdb_val      LD data
//   st_done      one-cycle pulse: STR has been written
//   st_rob_idx   tag of the completed STR
//   illegal_op   one-cycle pulse: an accepted opcode was neither LD nor STR
//   stall_cnt    CDB stall count (MEM_STALL_CNT_EN only)
//   mem_busy     unit is not IDLE
// ----------------------------------------------------------------------------
module mem_unit_sequencer #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 3,
    parameter int ROB_W   = 2,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_opcode,
    input  logic [DATA_W-1:0] req_val,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ROB_W-1:0]  req_rob_idx,
    output logic              cdb_req,
    input  logic              cdb_gnt,
    output logic [ROB_W-1:0]  cdb_rob_idx,
    output logic [DATA_W-1:0] cdb_val,
    output logic              st_done,
    output logic [ROB_W-1:0]  st_rob_idx,
    output logic              illegal_op,
`ifdef MEM_STALL_CNT_EN
    output logic [7:0]        stall_cnt,
`endif
    output logic              mem_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    // The access counter only has to hold MEM_LAT-1.
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [2:0]       OP_LD    = 3'b101;
    localparam logic [2:0]       OP_STR   = 3'b110;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_CDB_WAIT = 2'd2,
        ST_ST_ACK   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [CNT_W-1:0]  cnt_r;
    logic              op_is_ld_r;
    logic [DATA_W-1:0] val_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ROB_W-1:0]  rob_idx_r;
    logic [DATA_W-1:0] cdb_val_r;
    logic              illegal_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              req_ready_s;
    logic              cdb_req_s;
    logic              st_done_s;
    logic              mem_busy_s;
    logic              accept_s;
    logic              op_legal_s;
    logic              last_access_s;

    // Accept an op whenever the RS offers one while the unit is idle.
    assign accept_s      = req_valid & req_ready_s;
    assign op_legal_s    = (req_opcode == OP_LD) | (req_opcode == OP_STR);
    assign last_access_s = (state_r == ST_ACCESS) & (cnt_r == CNT_ZERO);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                // Illegal opcodes are consumed without leaving IDLE.
                if (accept_s && op_legal_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = op_is_ld_r ? ST_CDB_WAIT : ST_ST_ACK;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_CDB_WAIT: begin
                // The stall on a missing grant has no upper bound.
                if (cdb_gnt) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CDB_WAIT;
                end
            end
            ST_ST_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode. This depends on the state register only, so no input reaches an output combinationally.
    always_comb begin
        req_ready_s = 1'b0;
        cdb_req_s   = 1'b0;
        st_done_s   = 1'b0;
        mem_busy_s  = 1'b1;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                mem_busy_s  = 1'b0;
            end
            ST_ACCESS: begin
                mem_busy_s  = 1'b1;
            end
            ST_CDB_WAIT: begin
                cdb_req_s   = 1'b1;
            end
            ST_ST_ACK: begin
                st_done_s   = 1'b1;
            end
            default: begin
                req_ready_s = 1'b0;
                mem_busy_s  = 1'b1;
            end
        endcase
    end

    // Latch the accepted op. The tag register also drives both ROB/CDB tag outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_is_ld_r <= 1'b0;
            val_r      <= {DATA_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            rob_idx_r  <= {ROB_W{1'b0}};
        end else if (accept_s && op_legal_s) begin
            op_is_ld_r <= (req_opcode == OP_LD);
            val_r      <= req_val;
            addr_r     <= req_addr;
            rob_idx_r  <= req_rob_idx;
        end
    end

    // Access counter. It is loaded with MEM_LAT-1 on accept, so ACCESS lasts exactly MEM_LAT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (accept_s && op_legal_s) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == ST_ACCESS) && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    // Data memory. A STR writes on its last access cycle. Reset wins, so an interrupted STR never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (last_access_s && !op_is_ld_r) begin
            mem_r[addr_r] <= val_r;
        end
    end

    // LD result register. It holds its value through CDB_WAIT until the grant arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_val_r <= {DATA_W{1'b0}};
        end else if (last_access_s && op_is_ld_r) begin
            cdb_val_r <= mem_r[addr_r];
        end
    end

    // Illegal-opcode flag. It pulses for the one cycle after the offending accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= accept_s & ~op_legal_s;
        end
    end

`ifdef MEM_STALL_CNT_EN
    logic [7:0] stall_cnt_r;

    // Saturating count of CDB cycles that were requested but not granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 8'd0;
        end else if (cdb_req_s && !cdb_gnt && (stall_cnt_r != 8'd255)) begin
            stall_cnt_r <= stall_cnt_r + 8'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    assign req_ready   = req_ready_s;
    assign cdb_req     = cdb_req_s;
    assign st_done     = st_done_s;
    assign mem_busy    = mem_busy_s;
    assign cdb_rob_idx = rob_idx_r;
    assign cdb_val     = cdb_val_r;
    assign st_rob_idx  = rob_idx_r;
    assign illegal_op  = illegal_r;

endmodule

// File: tb/tb_mem_unit_sequencer.sv
module tb_mem_unit_sequencer;

    localparam int LAT = 2;
    localparam logic [2:0] LD  = 3'b101;
    localparam logic [2:0] STR = 3'b110;
    // {req_ready, cdb_req, st_done, illegal_op, mem_busy, cdb_rob_idx, cdb_val, st_rob_idx}
    localparam logic [11:0] RST_VEC = 12'b1_0_0_0_0_00_000_00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_opcode = 3'b000;
    logic [2:0] req_val = 3'd0;
    logic [1:0] req_addr = 2'd0;
    logic [1:0] req_rob_idx = 2'd0;
    logic       cdb_req;
    logic       cdb_gnt = 1'b0;
    logic [1:0] cdb_rob_idx;
    logic [2:0] cdb_val;
    logic       st_done;
    logic [1:0] st_rob_idx;
    logic       illegal_op;
    logic       mem_busy;
`ifdef MEM_STALL_CNT_EN
    logic [7:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Behavioural memory model.
    logic [2:0] ref_mem [4];

    // Observations collected by run_op.
    int         obs_lat;
    logic [2:0] obs_val;
    logic [1:0] obs_tag;
    bit         obs_unstable;
    int         obs_done_cnt;
    bit         obs_timeout;
    logic       obs_ready;

    mem_unit_sequencer #(.ADDR_W(2), .DATA_W(3), .ROB_W(2), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_val(req_val), .req_addr(req_addr), .req_rob_idx(req_rob_idx),
        .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val),
        .st_done(st_done), .st_rob_idx(st_rob_idx), .illegal_op(illegal_op),
`ifdef MEM_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [11:0] out_vec();
        return {req_ready, cdb_req, st_done, illegal_op, mem_busy, cdb_rob_idx, cdb_val, st_rob_idx};
    endfunction

    // Drives one op and records what the DUT does with it; the callers do the checking.
    // n counts negedges after the accept edge, so n = LAT+1 is where the result should first appear.
    task automatic run_op(input logic [2:0] op, input logic [2:0] v, input logic [1:0] a,
                          input logic [1:0] t, input int gw, input bit poke);
        int  stalls = 0;
        bit  done = 0;
        obs_lat = -1; obs_val = 3'd0; obs_tag = 2'd0; obs_unstable = 0;
        obs_done_cnt = 0; obs_timeout = 0;
        @(negedge clk);
        req_valid = 1'b1; req_opcode = op; req_val = v; req_addr = a; req_rob_idx = t;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(negedge clk);
            if (poke && n == 1) begin
                req_valid = 1'b1; req_opcode = STR; req_addr = a + 2'd1; req_val = ~v;
            end else begin
                req_valid = 1'b0;
            end
            if (cdb_req) begin
                if (obs_lat < 0) begin
                    obs_lat = n; obs_val = cdb_val; obs_tag = cdb_rob_idx;
                end else if (cdb_val !== obs_val || cdb_rob_idx !== obs_tag) begin
                    obs_unstable = 1;
                end
                if (stalls < gw) begin
                    cdb_gnt = 1'b0; stalls++;
                end else begin
                    cdb_gnt = 1'b1;
                    @(posedge clk); #1;
                    cdb_gnt = 1'b0;
                    done = 1;
                end
            end
            if (st_done) begin
                obs_done_cnt++;
                if (obs_lat < 0) begin
                    obs_lat = n; obs_tag = st_rob_idx;
                end
            end else if (op == STR && obs_lat >= 0) begin
                done = 1;
            end
        end
        req_valid = 1'b0;
        obs_timeout = !done;
        @(negedge clk);
        obs_ready = req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 3'd0;
        @(negedge clk);
        n_vec++;
        if (out_vec() !== RST_VEC) begin
            n_err++; $display("FAIL reset_outputs: got %b expected %b", out_vec(), RST_VEC);
        end
`ifdef MEM_STALL_CNT_EN
        n_vec++;
        if (stall_cnt !== 8'd0) begin
            n_err++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_ld_basic();
        run_op(LD, 3'd0, 2'd2, 2'd1, 0, 0);
        n_vec++;
        if (obs_timeout || obs_lat != LAT + 1) begin
            n_err++; $display("FAIL ld_latency: got %0d expected %0d (timeout=%0d)", obs_lat, LAT + 1, obs_timeout);
        end
        n_vec++;
        if (obs_val !== ref_mem[2] || obs_tag !== 2'd1) begin
            n_err++; $display("FAIL ld_result: got val=%0d tag=%0d expected val=%0d tag=1", obs_val, obs_tag, ref_mem[2]);
        end
        n_vec++;
        if (obs_ready !== 1'b1) begin
            n_err++; $display("FAIL ld_ready_after: got %b expected 1", obs_ready);
        end
    endtask

    task automatic test_str_ld();
        run_op(STR, 3'd5, 2'd3, 2'd2, 0, 0);
        ref_mem[3] = 3'd5;
        n_vec++;
        if (obs_timeout || obs_lat != LAT + 1 || obs_tag !== 2'd2 || obs_done_cnt != 1) begin
            n_err++; $display("FAIL str_done: got lat=%0d tag=%0d pulses=%0d expected lat=%0d tag=2 pulses=1",
                              obs_lat, obs_tag, obs_done_cnt, LAT + 1);
        end
        run_op(LD, 3'd0, 2'd3, 2'd3, 0, 0);
        n_vec++;
        if (obs_timeout || obs_val !== ref_mem[3] || obs_tag !== 2'd3) begin
            n_err++; $display("FAIL ld_after_str: got val=%0d tag=%0d expected val=%0d tag=3", obs_val, obs_tag, ref_mem[3]);
        end
    endtask

    task automatic test_gnt_stall();
        logic [2:0] v = 3'($urandom_range(1, 7));
`ifdef MEM_STALL_CNT_EN
        int before;
`endif
        run_op(STR, v, 2'd0, 2'd0, 0, 0);
        ref_mem[0] = v;
`ifdef MEM_STALL_CNT_EN
        before = int'(stall_cnt);
`endif
        run_op(LD, 3'd0, 2'd0, 2'd1, 4, 0);
        n_vec++;
        if (obs_timeout || obs_lat != LAT + 1 || obs_unstable) begin
            n_err++; $display("FAIL stall_hold: got lat=%0d unstable=%0d timeout=%0d expected lat=%0d unstable=0",
                              obs_lat, obs_unstable, obs_timeout, LAT + 1);
        end
        n_vec++;
        if (obs_val !== ref_mem[0] || obs_tag !== 2'd1) begin
            n_err++; $display("FAIL stall_result: got val=%0d tag=%0d expected val=%0d tag=1", obs_val, obs_tag, ref_mem[0]);
        end
`ifdef MEM_STALL_CNT_EN
        n_vec++;
        if (int'(stall_cnt) != ((before + 4 > 255) ? 255 : before + 4)) begin
            n_err++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, before + 4);
        end
`endif
    endtask

    task automatic test_ignore_busy();
        logic [1:0] a = 2'($urandom);
        logic [2:0] v = 3'($urandom);
        run_op(STR, v, a, 2'd3, 0, 1);
        ref_mem[a] = v;
        n_vec++;
        if (obs_timeout || obs_done_cnt != 1 || obs_tag !== 2'd3) begin
            n_err++; $display("FAIL busy_str: got pulses=%0d tag=%0d expected pulses=1 tag=3", obs_done_cnt, obs_tag);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (mem_busy !== 1'b0) begin
            n_err++; $display("FAIL busy_no_second_op: got mem_busy=%b expected 0", mem_busy);
        end
        run_op(LD, 3'd0, a + 2'd1, 2'd0, 0, 0);
        n_vec++;
        if (obs_val !== ref_mem[a + 2'd1]) begin
            n_err++; $display("FAIL busy_mem_untouched: got %0d expected %0d", obs_val, ref_mem[a + 2'd1]);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        req_valid = 1'b1; req_opcode = 3'b011; req_addr = 2'd1; req_val = 3'd7; req_rob_idx = 2'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({illegal_op, req_ready, mem_busy, cdb_req, st_done} !== 5'b11000) begin
            n_err++; $display("FAIL illegal_pulse: got %b expected 11000",
                              {illegal_op, req_ready, mem_busy, cdb_req, st_done});
        end
        @(negedge clk);
        n_vec++;
        if ({illegal_op, mem_busy, cdb_req, st_done} !== 4'b0000) begin
            n_err++; $display("FAIL illegal_one_cycle: got %b expected 0000", {illegal_op, mem_busy, cdb_req, st_done});
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        bit got_req = 0;
        // A STR interrupted by reset in its last access cycle must never land.
        @(negedge clk);
        req_valid = 1'b1; req_opcode = STR; req_val = 3'd7; req_addr = 2'd1; req_rob_idx = 2'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (LAT) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 3'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (st_done) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++; $display("FAIL reset_mid_no_done: got %0d pulses expected 0", seen);
        end
        run_op(LD, 3'd0, 2'd1, 2'd2, 0, 0);
        n_vec++;
        if (obs_timeout || obs_val !== 3'd0) begin
            n_err++; $display("FAIL reset_mid_ld: got %0d expected 0", obs_val);
        end
        // Reset while a LD result is waiting for the CDB.
        run_op(STR, 3'd6, 2'd0, 2'd1, 0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_opcode = LD; req_addr = 2'd0; req_rob_idx = 2'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !got_req; i++) begin
            @(negedge clk);
            got_req = cdb_req;
        end
        n_vec++;
        if (!got_req || cdb_val !== 3'd6) begin
            n_err++; $display("FAIL cdb_wait_entry: got req=%0d val=%0d expected req=1 val=6", got_req, cdb_val);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_vec() !== RST_VEC) begin
            n_err++; $display("FAIL reset_in_cdb_wait: got %b expected %b", out_vec(), RST_VEC);
        end
        for (int i = 0; i < 4; i++) ref_mem[i] = 3'd0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [2:0] op = ($urandom_range(0, 1) == 0) ? LD : STR;
            logic [2:0] v  = 3'($urandom);
            logic [1:0] a  = 2'($urandom);
            logic [1:0] t  = 2'($urandom);
            int         gw = $urandom_range(0, 3);
            bit         pk = ($urandom_range(0, 3) == 0);
            run_op(op, v, a, t, gw, pk);
            n_vec++;
            if (obs_timeout || obs_lat != LAT + 1 || obs_ready !== 1'b1) begin
                n_err++; $display("FAIL rand_timing[%0d]: got lat=%0d ready=%b timeout=%0d expected lat=%0d ready=1",
                                  k, obs_lat, obs_ready, obs_timeout, LAT + 1);
            end
            n_vec++;
            if (op == LD) begin
                if (obs_val !== ref_mem[a] || obs_tag !== t || obs_unstable) begin
                    n_err++; $display("FAIL rand_ld[%0d]: got val=%0d tag=%0d expected val=%0d tag=%0d",
                                      k, obs_val, obs_tag, ref_mem[a], t);
                end
            end else begin
                ref_mem[a] = v;
                if (obs_tag !== t || obs_done_cnt != 1) begin
                    n_err++; $display("FAIL rand_str[%0d]: got tag=%0d pulses=%0d expected tag=%0d pulses=1",
                                      k, obs_tag, obs_done_cnt, t);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ld_basic();
        test_str_ld();
        test_gnt_stall();
        test_ignore_busy();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
